// File: rtl/ads131a0x_spi_responder.sv
// rtl/ads131a0x_spi_responder.sv - ADS131A0x-side SPI responder: status + channel words out, command word in
// Define ADS131_RESP_CRC_EN to append a CRC-16-CCITT word to every frame.
module ads131a0x_spi_responder #(
  parameter int WORD_BITS = 24,
  parameter int NUM_CH    = 4
) (
  input  logic                        system_clock,
  input  logic                        reset,
  input  logic                        SPI_SCLK,
  input  logic                        SPI_CS,
  input  logic                        SPI_MOSI,
  output logic                        SPI_MISO,
  input  logic [15:0]                 status_word,
  input  logic [NUM_CH*WORD_BITS-1:0] ch_data,
  input  logic                        sample_valid,
  output logic                        drdy_n,
  output logic [15:0]                 cmd_word,
  output logic                        cmd_valid,
  output logic                        frame_error
);
`ifdef ADS131_RESP_CRC_EN
  localparam int FRAME_WORDS = NUM_CH + 2;
`else
  localparam int FRAME_WORDS = NUM_CH + 1;
`endif
  localparam int DATA_BITS  = (NUM_CH + 1) * WORD_BITS;
  localparam int FRAME_BITS = FRAME_WORDS * WORD_BITS;
  localparam int CW         = $clog2(FRAME_BITS + 2);
  localparam logic [CW-1:0] CNT_MAX   = CW'(FRAME_BITS + 1);
  localparam logic [CW-1:0] CNT_FRAME = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_WORD  = CW'(WORD_BITS);
  localparam logic [CW-1:0] CNT_CMD   = CW'(WORD_BITS - 1);
`ifdef ADS131_RESP_CRC_EN
  localparam logic [CW-1:0] CNT_DATA  = CW'(DATA_BITS);
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                        state_q, state_d;
  logic                          sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic                          cs_s1_q, cs_s2_q, cs_s3_q;
  logic                          mosi_s1_q, mosi_s2_q;
  logic                          wu1_q, wu2_q, cs_armed_q, cs_armed_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [DATA_BITS-1:0]          tx_q, tx_d;
  logic [WORD_BITS-1:0]          rx_q, rx_d;
  logic [NUM_CH*WORD_BITS-1:0]   hold_q, hold_d;
  logic                          miso_q, miso_d, drdy_q, drdy_d;
  logic [15:0]                   cmd_word_q, cmd_word_d;
  logic                          cmd_valid_q, cmd_valid_d, ferr_q, ferr_d;
  logic                          sclk_rise, sclk_fall, cs_fall, cs_rise;
`ifdef ADS131_RESP_CRC_EN
  logic [15:0]                   crc_q, crc_d;
`endif

  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  assign sclk_fall = ~sclk_s2_q & sclk_s3_q;
  // Only a CS fall seen after CS was genuinely sampled high may open a frame, so a
  // master still holding CS low across reset cannot start a truncated frame.
  assign cs_fall   = ~cs_s2_q & cs_s3_q & cs_armed_q;
  assign cs_rise   = cs_s2_q & ~cs_s3_q;
  assign cs_armed_d = cs_armed_q | (wu2_q & cs_s2_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    hold_d      = hold_q;
    miso_d      = miso_q;
    drdy_d      = drdy_q;
    cmd_word_d  = cmd_word_q;
    cmd_valid_d = 1'b0;
    ferr_d      = 1'b0;
`ifdef ADS131_RESP_CRC_EN
    crc_d       = crc_q;
`endif
    if (sample_valid) hold_d = ch_data;
    case (state_q)
      IDLE: if (cs_fall) begin
        state_d = SHIFT;
        tx_d    = '0;
        tx_d[DATA_BITS-1 -: 16]          = status_word;
        tx_d[NUM_CH*WORD_BITS-1:0]       = hold_q;
        cnt_d   = '0;
        rx_d    = '0;
        miso_d  = 1'b0;
        drdy_d  = 1'b1;
`ifdef ADS131_RESP_CRC_EN
        crc_d   = 16'hFFFF;
`endif
      end
      SHIFT: if (cs_rise) begin
        state_d = IDLE;
        miso_d  = 1'b0;
        ferr_d  = (cnt_q != CNT_FRAME);
      end else begin
        if (sclk_rise) begin
`ifdef ADS131_RESP_CRC_EN
          // Data bits feed the CRC; afterwards the frozen CRC is shifted out, then zeros.
          if (cnt_q < CNT_DATA) begin
            miso_d = tx_q[DATA_BITS-1];
            tx_d   = tx_q << 1;
            crc_d  = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ tx_q[DATA_BITS-1]) ? 16'h1021 : 16'h0000);
          end else begin
            miso_d = crc_q[15];
            crc_d  = {crc_q[14:0], 1'b0};
          end
`else
          miso_d = tx_q[DATA_BITS-1];
          tx_d   = tx_q << 1;
`endif
        end
        if (sclk_fall) begin
          if (cnt_q < CNT_WORD) rx_d = {rx_q[WORD_BITS-2:0], mosi_s2_q};
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_CMD) begin
            cmd_word_d  = rx_d[WORD_BITS-1 -: 16];
            cmd_valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A new sample always wins over the drdy release at cs_fall.
    if (sample_valid) drdy_d = 1'b0;
  end

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_s3_q   <= 1'b0;
      cs_s1_q     <= 1'b1;
      cs_s2_q     <= 1'b1;
      cs_s3_q     <= 1'b1;
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
      wu1_q       <= 1'b0;
      wu2_q       <= 1'b0;
      cs_armed_q  <= 1'b0;
      cnt_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      hold_q      <= '0;
      miso_q      <= 1'b0;
      drdy_q      <= 1'b1;
      cmd_word_q  <= '0;
      cmd_valid_q <= 1'b0;
      ferr_q      <= 1'b0;
`ifdef ADS131_RESP_CRC_EN
      crc_q       <= 16'hFFFF;
`endif
    end else begin
      state_q     <= state_d;
      sclk_s1_q   <= SPI_SCLK;
      sclk_s2_q   <= sclk_s1_q;
      sclk_s3_q   <= sclk_s2_q;
      cs_s1_q     <= SPI_CS;
      cs_s2_q     <= cs_s1_q;
      cs_s3_q     <= cs_s2_q;
      mosi_s1_q   <= SPI_MOSI;
      mosi_s2_q   <= mosi_s1_q;
      wu1_q       <= 1'b1;
      wu2_q       <= wu1_q;
      cs_armed_q  <= cs_armed_d;
      cnt_q       <= cnt_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      hold_q      <= hold_d;
      miso_q      <= miso_d;
      drdy_q      <= drdy_d;
      cmd_word_q  <= cmd_word_d;
      cmd_valid_q <= cmd_valid_d;
      ferr_q      <= ferr_d;
`ifdef ADS131_RESP_CRC_EN
      crc_q       <= crc_d;
`endif
    end
  end

  assign SPI_MISO    = miso_q;
  assign drdy_n      = drdy_q;
  assign cmd_word    = cmd_word_q;
  assign cmd_valid   = cmd_valid_q;
  assign frame_error = ferr_q;
endmodule

// File: tb/tb_ads131a0x_spi_responder.sv
// tb/tb_ads131a0x_spi_responder.sv - scoreboard bench for ads131a0x_spi_responder
// Reference frames are built from the snapshot rules; CRC is computed by polynomial long division.
module tb_ads131a0x_spi_responder;
  localparam int WB  = 24;
  localparam int NCH = 4;
`ifdef ADS131_RESP_CRC_EN
  localparam int FW = NCH + 2;
`else
  localparam int FW = NCH + 1;
`endif
  localparam int FB = FW * WB;

  logic                clk = 1'b0, rst = 1'b1;
  logic                sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
  logic                miso, drdy_n, cmd_valid, frame_error;
  logic [15:0]         status = 16'h0, cmd_word;
  logic [NCH*WB-1:0]   ch = '0, model_hold = '0;
  logic                sv = 1'b0;

  int vectors = 0, miscompares = 0;
  bit          exp_bits[$];
  logic [15:0] exp_cmd[$];
  bit          exp_ferr[$];

  ads131a0x_spi_responder #(.WORD_BITS(WB), .NUM_CH(NCH)) dut (
    .system_clock(clk), .reset(rst), .SPI_SCLK(sclk), .SPI_CS(cs), .SPI_MOSI(mosi),
    .SPI_MISO(miso), .status_word(status), .ch_data(ch), .sample_valid(sv),
    .drdy_n(drdy_n), .cmd_word(cmd_word), .cmd_valid(cmd_valid), .frame_error(frame_error)
  );

  always #10 clk = ~clk;

  initial begin
    #4000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [NCH*WB-1:0] rand_data();
    logic [NCH*WB-1:0] d;
    for (int c = 0; c < NCH; c++) d[c*WB +: WB] = WB'($urandom);
    return d;
  endfunction

  // Remainder of (message with first 16 bits inverted, followed by 16 zeros) mod x^16+x^12+x^5+1.
  function automatic logic [15:0] crc_ref(input bit m[$]);
    logic [16:0] rem = '0;
    bit b;
    for (int i = 0; i < m.size() + 16; i++) begin
      b = (i < m.size()) ? m[i] : 1'b0;
      if (i < 16) b = ~b;
      rem = {rem[15:0], b};
      if (rem[16]) rem = rem ^ 17'h11021;
    end
    return rem[15:0];
  endfunction

  task automatic push_frame(input int nbits, input logic [WB-1:0] cmd);
    bit fr[$];
    logic [WB-1:0] w;
    w = {status, 8'h00};
    for (int i = WB - 1; i >= 0; i--) fr.push_back(w[i]);
    for (int c = 0; c < NCH; c++) begin
      w = model_hold[(NCH-c)*WB-1 -: WB];
      for (int i = WB - 1; i >= 0; i--) fr.push_back(w[i]);
    end
`ifdef ADS131_RESP_CRC_EN
    w = {crc_ref(fr), 8'h00};
    for (int i = WB - 1; i >= 0; i--) fr.push_back(w[i]);
`endif
    for (int i = 0; i < nbits; i++) exp_bits.push_back((i < fr.size()) ? fr[i] : 1'b0);
    if (nbits >= WB) exp_cmd.push_back(cmd[WB-1 -: 16]);
    if (nbits != FB) exp_ferr.push_back(1'b1);
  endtask

  task automatic do_sample(input logic [NCH*WB-1:0] d);
    @(negedge clk);
    ch = d; sv = 1'b1;
    @(negedge clk);
    sv = 1'b0;
    model_hold = d;
    check("drdy_after_sample", drdy_n, 1'b0);
  endtask

  task automatic run_frame(input int nbits, input logic [WB-1:0] cmd, input int mid_at);
    push_frame(nbits, cmd);
    cs = 1'b0;
    wait_clks(6);
    check("drdy_at_cs_fall", drdy_n, 1'b1);
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b1;
      mosi = (i < WB) ? cmd[WB-1-i] : 1'($urandom);
      wait_clks(6);
      sclk = 1'b0;
      wait_clks(6);
      if (i == mid_at) do_sample(rand_data());
    end
    cs = 1'b1;
    wait_clks(12);
  endtask

  // MISO is read at each SCLK fall, the master's CPHA=1 sampling point.
  always @(negedge sclk) begin
    if (!cs) begin
      vectors++;
      if (exp_bits.size() == 0) begin
        miscompares++;
        $display("FAIL miso_unexpected_bit: got %0b expected none", miso);
      end else if (miso !== exp_bits[0]) begin
        miscompares++;
        $display("FAIL miso_bit: got %0b expected %0b (%0d bits left)", miso, exp_bits[0], exp_bits.size());
        void'(exp_bits.pop_front());
      end else begin
        void'(exp_bits.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (cmd_valid) begin
      vectors++;
      if (exp_cmd.size() == 0) begin
        miscompares++;
        $display("FAIL cmd_unexpected: got %0h expected no pulse", cmd_word);
      end else begin
        if (cmd_word !== exp_cmd[0]) begin
          miscompares++;
          $display("FAIL cmd_word: got %0h expected %0h", cmd_word, exp_cmd[0]);
        end
        void'(exp_cmd.pop_front());
      end
    end
    if (frame_error) begin
      vectors++;
      if (exp_ferr.size() == 0) begin
        miscompares++;
        $display("FAIL frame_error_unexpected: got 1 expected 0");
      end else begin
        void'(exp_ferr.pop_front());
      end
    end
  end

  initial begin
    wait_clks(5);
    check("reset_miso", miso, 1'b0);
    check("reset_drdy_n", drdy_n, 1'b1);
    check("reset_cmd_valid", cmd_valid, 1'b0);
    check("reset_frame_error", frame_error, 1'b0);
    check("reset_cmd_word", cmd_word, 16'h0);
    rst = 1'b0;
    wait_clks(6);

    status = 16'h2200;
    do_sample({24'h123456, 24'hABCDEF, 24'h000001, 24'hFFFFFF});
    run_frame(FB, 24'h011000, -1);
    check("drdy_after_plain_frame", drdy_n, 1'b1);

    do_sample(rand_data());
    run_frame(FB, WB'($urandom), 40);
    check("drdy_after_mid_sample", drdy_n, 1'b0);
    run_frame(FB, WB'($urandom), -1);

    run_frame(100, WB'($urandom), -1);
    do_sample(rand_data());
    run_frame(130, WB'($urandom), -1);
    run_frame(10, WB'($urandom), -1);

    for (int k = 0; k < 5; k++) begin
      status = 16'($urandom);
      if ($urandom_range(1, 0) == 1) do_sample(rand_data());
      run_frame(FB + ((k == 4) ? 3 : 0), WB'($urandom), (k == 2) ? 70 : -1);
    end

    wait_clks(20);
    check("miso_bits_outstanding", exp_bits.size(), 0);
    check("cmd_pulses_outstanding", exp_cmd.size(), 0);
    check("frame_error_outstanding", exp_ferr.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
